// File: rtl/weigh_pkg.sv
// Shared constants for the weight-to-ASCII frame transmitter: ASCII codes, FSM state
// encodings and the BCD digit count.
package weigh_pkg;

  localparam int unsigned BcdDigits    = 6;
  localparam int unsigned BinWidth     = 20;
  localparam int unsigned WaitHiCycles = 3;

  localparam logic [7:0] AsciiPlus  = 8'h2B;
  localparam logic [7:0] AsciiMinus = 8'h2D;
  localparam logic [7:0] AsciiDot   = 8'h2E;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;
  localparam logic [7:0] AsciiZero  = 8'h30;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StConv   = 3'd1;
  localparam logic [2:0] StSend   = 3'd2;
  localparam logic [2:0] StWaitHi = 3'd3;
  localparam logic [2:0] StWaitLo = 3'd4;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one input bit per cycle, BinWidth cycles
// after start; done is high during the cycle whose closing edge finishes the last shift.
module bin2bcd_seq
  import weigh_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BinWidth-1:0]    bin,
  output logic                   done,
  output logic [4*BcdDigits-1:0] bcd
);

  localparam int unsigned BcdW = 4 * BcdDigits;

  logic [BinWidth-1:0] shift_q, shift_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, adj;
  logic [4:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;

  always_comb begin
    adj = '0;
    for (int i = 0; i < BcdDigits; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      shift_d = bin;
      bcd_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      bcd_d   = {adj[BcdW-2:0], shift_q[BinWidth-1]};
      shift_d = {shift_q[BinWidth-2:0], 1'b0};
      cnt_d   = cnt_q + 5'd1;
      if (cnt_q == 5'(BinWidth - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == 5'(BinWidth - 1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/weight_ascii_tx.sv
// Converts a signed 20-bit weight to an ASCII frame (sign, digits, optional '.', CR, LF)
// and feeds it byte by byte to a UART transmitter using a write strobe / busy handshake.
module weight_ascii_tx
  import weigh_pkg::*;
#(
  parameter int unsigned DP_POS = 1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [19:0] weight_i,
  input  logic        weight_vld_i,
  output logic        rdy_o,
  input  logic        uart_busy_i,
  output logic        uart_wr_o,
  output logic [7:0]  uart_dat_o,
  output logic        frame_done_o
);

  localparam int unsigned NumInt   = BcdDigits - DP_POS;
  localparam int unsigned FrameLen = BcdDigits + 3 + ((DP_POS > 0) ? 1 : 0);
  localparam logic [3:0]  LastIdx  = 4'(FrameLen - 1);
  localparam logic [3:0]  IdxCr    = 4'(FrameLen - 2);
  localparam logic [3:0]  IdxDot   = 4'(NumInt + 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  hi_cnt_q, hi_cnt_d;
  logic        sign_q, sign_d;
  logic        wr_q, wr_d;
  logic [7:0]  dat_q, dat_d;
  logic        accept, conv_done;
  logic [19:0] mag;
  logic [23:0] bcd_val;
  logic [2:0]  digit_sel;
  logic [3:0]  digit;
  logic [7:0]  byte_val;

  assign rdy_o  = (state_q == StIdle);
  assign accept = weight_vld_i & rdy_o;
  // -524288 negates to itself, which read as unsigned is the correct magnitude.
  assign mag    = weight_i[19] ? -weight_i : weight_i;

  bin2bcd_seq u_bin2bcd (
    .clk   (sys_clk_i),
    .rst   (sys_rst_i),
    .start (accept),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd_val)
  );

  // Byte mux: digit 0 is the most significant BCD digit.
  always_comb begin
    digit_sel = 3'(idx_q - 4'd1);
    if (DP_POS > 0 && idx_q > IdxDot) digit_sel = 3'(idx_q - 4'd2);
    case (digit_sel)
      3'd0:    digit = bcd_val[23:20];
      3'd1:    digit = bcd_val[19:16];
      3'd2:    digit = bcd_val[15:12];
      3'd3:    digit = bcd_val[11:8];
      3'd4:    digit = bcd_val[7:4];
      default: digit = bcd_val[3:0];
    endcase
    byte_val = AsciiZero + {4'd0, digit};
    if (idx_q == 4'd0)                          byte_val = sign_q ? AsciiMinus : AsciiPlus;
    else if (idx_q == LastIdx)                  byte_val = AsciiLf;
    else if (idx_q == IdxCr)                    byte_val = AsciiCr;
    else if (DP_POS > 0 && idx_q == IdxDot)     byte_val = AsciiDot;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hi_cnt_d     = hi_cnt_q;
    sign_d       = sign_q;
    wr_d         = 1'b0;
    dat_d        = dat_q;
    frame_done_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          sign_d  = weight_i[19];
          idx_d   = 4'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        if (conv_done) state_d = StSend;
      end
      StSend: begin
        if (!uart_busy_i) begin
          wr_d     = 1'b1;
          dat_d    = byte_val;
          hi_cnt_d = 2'd0;
          state_d  = StWaitHi;
        end
      end
      StWaitHi: begin
        // A UART that never raises busy must not stall the frame.
        if (uart_busy_i || hi_cnt_q == 2'(WaitHiCycles - 1)) state_d = StWaitLo;
        else hi_cnt_d = hi_cnt_q + 2'd1;
      end
      StWaitLo: begin
        if (!uart_busy_i) begin
          if (idx_q == LastIdx) begin
            idx_d        = 4'd0;
            state_d      = StIdle;
            frame_done_o = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      hi_cnt_q <= 2'd0;
      sign_q   <= 1'b0;
      wr_q     <= 1'b0;
      dat_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hi_cnt_q <= hi_cnt_d;
      sign_q   <= sign_d;
      wr_q     <= wr_d;
      dat_q    <= dat_d;
    end
  end

  assign uart_wr_o  = wr_q;
  assign uart_dat_o = dat_q;

endmodule

// File: tb/tb_weight_ascii_tx.sv
// Scoreboard bench for weight_ascii_tx: one DUT with DP_POS=1 and one with DP_POS=0.
module tb_weight_ascii_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] weight = '0, weight0 = '0;
  logic        vld = 1'b0, vld0 = 1'b0;
  logic        busy_force = 1'b0;
  logic        real_uart = 1'b0;
  logic        busy0 = 1'b0;
  int          busy_cnt = 0;
  logic        busy;
  logic        rdy, wr, done, rdy0, wr0, done0;
  logic [7:0]  dat, dat0;

  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0, done_cnt = 0, wr0_cnt = 0, done0_cnt = 0;
  logic        prev_wr = 1'b0, prev_wr0 = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp0_q[$];
  logic [7:0]  frame_q[$];

  always #5 clk = ~clk;

  assign busy = busy_force | (busy_cnt != 0);

  weight_ascii_tx #(.DP_POS(1)) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .weight_i     (weight),
    .weight_vld_i (vld),
    .rdy_o        (rdy),
    .uart_busy_i  (busy),
    .uart_wr_o    (wr),
    .uart_dat_o   (dat),
    .frame_done_o (done)
  );

  weight_ascii_tx #(.DP_POS(0)) dut0 (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .weight_i     (weight0),
    .weight_vld_i (vld0),
    .rdy_o        (rdy0),
    .uart_busy_i  (busy0),
    .uart_wr_o    (wr0),
    .uart_dat_o   (dat0),
    .frame_done_o (done0)
  );

  // 115200 baud at 50 MHz: 434 cycles per bit, 10 bits per byte.
  always @(posedge clk) begin
    if (wr === 1'b1 && real_uart) busy_cnt <= 4340;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (wr === 1'b1) begin
      wr_cnt++;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL wr_while_busy: uart_busy_i=%b, required 0 during strobe", busy);
      end
      checks++;
      if (prev_wr === 1'b1) begin
        errors++;
        $display("FAIL wr_consecutive: uart_wr_o high on two cycles, required single pulse");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, required no strobe", dat);
      end else begin
        e = exp_q.pop_front();
        if (dat !== e) begin
          errors++;
          $display("FAIL frame_byte: got %02h, required %02h", dat, e);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
    prev_wr = wr;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (wr0 === 1'b1) begin
      wr0_cnt++;
      checks++;
      if (prev_wr0 === 1'b1) begin
        errors++;
        $display("FAIL dp0_wr_consecutive: uart_wr_o high on two cycles, required single pulse");
      end
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL dp0_unexpected_byte: got %02h, required no strobe", dat0);
      end else begin
        e = exp0_q.pop_front();
        if (dat0 !== e) begin
          errors++;
          $display("FAIL dp0_frame_byte: got %02h, required %02h", dat0, e);
        end
      end
    end
    if (done0 === 1'b1) done0_cnt++;
    prev_wr0 = wr0;
  end

  task automatic build_frame(input int w, input int dp);
    int mag;
    int dig[6];
    frame_q.delete();
    mag = (w < 0) ? -w : w;
    for (int i = 5; i >= 0; i--) begin
      dig[i] = mag % 10;
      mag    = mag / 10;
    end
    frame_q.push_back((w < 0) ? 8'h2D : 8'h2B);
    for (int i = 0; i < 6; i++) begin
      if (dp > 0 && i == 6 - dp) frame_q.push_back(8'h2E);
      frame_q.push_back(8'(8'h30 + dig[i]));
    end
    frame_q.push_back(8'h0D);
    frame_q.push_back(8'h0A);
  endtask

  // Waits for rdy, drives a one-cycle request and queues the expected frame.
  task automatic request(input bit which, input int w, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ((which ? rdy0 : rdy) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) return;
    @(negedge clk);
    build_frame(w, which ? 0 : 1);
    if (which) begin
      weight0 = 20'(w);
      vld0    = 1'b1;
      foreach (frame_q[i]) exp0_q.push_back(frame_q[i]);
    end else begin
      weight = 20'(w);
      vld    = 1'b1;
      foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
    end
    @(posedge clk);
    #1;
    vld  = 1'b0;
    vld0 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget, output bit ok);
    int start;
    start = which ? done0_cnt : done_cnt;
    ok    = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if ((which ? done0_cnt : done_cnt) > start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b, required 1", rdy); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b, required 0", wr); end
    checks++; if (dat !== 8'h00) begin errors++; $display("FAIL reset_dat: got %02h, required 00", dat); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rdy0: got %b, required 1", rdy0); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL post_reset_rdy: got %b, required 1", rdy); end
  endtask

  task automatic test_basic;
    bit ok;
    int lat, w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    lat = -1;
    request(1'b0, 12345, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_request: rdy never high, required 1"); end
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (wr === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat != 21) begin errors++; $display("FAIL first_strobe_latency: got %0d, required 21", lat); end
    wait_done(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: no frame_done_o, required pulse"); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0); end
    checks++; if (wr_cnt - w0 != 10) begin errors++; $display("FAIL basic_byte_count: got %0d, required 10", wr_cnt - w0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_pending: got %0d, required 0", exp_q.size()); end
    checks++; if (dat !== 8'h0A) begin errors++; $display("FAIL dat_hold: got %02h, required 0a", dat); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy_after: got %b, required 1", rdy); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int d0;
    d0 = done_cnt;
    request(1'b0, -1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_request1: rdy never high, required 1"); end
    request(1'b0, -524288, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_request2: rdy never high, required 1"); end
    wait_done(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: no frame_done_o, required pulse"); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_dp0;
    bit ok;
    int w0, d0;
    w0 = wr0_cnt;
    d0 = done0_cnt;
    request(1'b1, 7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dp0_request: rdy never high, required 1"); end
    wait_done(1'b1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dp0_done_timeout: no frame_done_o, required pulse"); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (wr0_cnt - w0 != 9) begin errors++; $display("FAIL dp0_byte_count: got %0d, required 9", wr0_cnt - w0); end
    checks++; if (done0_cnt - d0 != 1) begin errors++; $display("FAIL dp0_done_count: got %0d, required 1", done0_cnt - d0); end
    checks++; if (exp0_q.size() != 0) begin errors++; $display("FAIL dp0_pending: got %0d, required 0", exp0_q.size()); end
  endtask

  task automatic test_busy_hold;
    bit ok, seen;
    int w0;
    @(negedge clk);
    busy_force = 1'b1;
    w0 = wr_cnt;
    request(1'b0, 20406, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_request: rdy never high, required 1"); end
    repeat (500) @(posedge clk);
    #1;
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL hold_no_strobe: got %0d strobes, required 0", wr_cnt - w0); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL hold_rdy: got %b, required 0", rdy); end
    @(negedge clk);
    busy_force = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      if (wr === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_release: no strobe after busy fell, required strobe"); end
    wait_done(1'b0, 200, ok);
    checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL hold_frame: done=%b pending=%0d, required done=1 pending=0", ok, exp_q.size()); end
  endtask

  task automatic test_ignore_vld;
    bit ok;
    int w0, d0, w1;
    w0 = wr_cnt;
    d0 = done_cnt;
    request(1'b0, 4321, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_request: rdy never high, required 1"); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    weight = 20'd999;
    vld    = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    for (int n = 0; n < 100 && wr_cnt == w0; n++) @(posedge clk);
    @(negedge clk);
    weight = 20'd777;
    vld    = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    wait_done(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout: no frame_done_o, required pulse"); end
    w1 = wr_cnt;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (wr_cnt != w1) begin errors++; $display("FAIL ign_extra_frame: got %0d strobes, required 0", wr_cnt - w1); end
    checks++; if (w1 - w0 != 10) begin errors++; $display("FAIL ign_byte_count: got %0d, required 10", w1 - w0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ign_done_count: got %0d, required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int w0;
    w0 = wr_cnt;
    request(1'b0, 54321, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_request: rdy never high, required 1"); end
    for (int n = 0; n < 200 && wr_cnt < w0 + 4; n++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (wr_cnt - w0 != 4) begin errors++; $display("FAIL mid_four_bytes: got %0d, required 4", wr_cnt - w0); end
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL mid_reset_wr: got %b, required 0", wr); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy_release: got %b, required 1", rdy); end
    w0 = wr_cnt;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL mid_resume: got %0d strobes, required 0", wr_cnt - w0); end
    request(1'b0, 54321, ok);
    wait_done(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_next_done: no frame_done_o, required pulse"); end
    checks++; if (wr_cnt - w0 != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_next_frame: got %0d bytes pending=%0d, required 10 pending=0", wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_real_uart;
    bit ok;
    int w0;
    real_uart = 1'b1;
    w0 = wr_cnt;
    request(1'b0, -98765, ok);
    checks++; if (!ok) begin errors++; $display("FAIL real_request: rdy never high, required 1"); end
    wait_done(1'b0, 50000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL real_done_timeout: no frame_done_o, required pulse"); end
    checks++; if (wr_cnt - w0 != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL real_frame: got %0d bytes pending=%0d, required 10 pending=0", wr_cnt - w0, exp_q.size());
    end
    real_uart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_dp0();
    test_busy_hold();
    test_ignore_vld();
    test_reset_mid();
    test_real_uart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
